// File: rtl/mem_copy_master.sv
// Second bus master that copies len words from src_addr to dst_addr over the shared memory bus.
// Bus outputs are registered from the FSM state, so the bus shows each state one cycle after the FSM enters it.
module mem_copy_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH-1:0] len,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [1:0]            mem_cmd,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] words_done
);

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR,
        FIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_WIDTH-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [1:0]            mem_cmd_q, mem_cmd_d;
    logic [DATA_WIDTH-1:0] write_data_q, write_data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] words_done_q, words_done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            src_ptr_q    <= '0;
            dst_ptr_q    <= '0;
            remaining_q  <= '0;
            mem_addr_q   <= '0;
            mem_cmd_q    <= MNONE;
            write_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            words_done_q <= '0;
        end else begin
            state_q      <= state_d;
            src_ptr_q    <= src_ptr_d;
            dst_ptr_q    <= dst_ptr_d;
            remaining_q  <= remaining_d;
            mem_addr_q   <= mem_addr_d;
            mem_cmd_q    <= mem_cmd_d;
            write_data_q <= write_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            words_done_q <= words_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_ptr_d    = src_ptr_q;
        dst_ptr_d    = dst_ptr_q;
        remaining_d  = remaining_q;
        mem_addr_d   = mem_addr_q;
        mem_cmd_d    = MNONE;
        write_data_d = write_data_q;
        done_d       = 1'b0;
        words_done_d = words_done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    words_done_d = '0;
                    if (len != '0) begin
                        src_ptr_d   = src_addr;
                        dst_ptr_d   = dst_addr;
                        remaining_d = len;
                        state_d     = RD_REQ;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            RD_REQ: begin
                mem_addr_d = src_ptr_q;
                mem_cmd_d  = MREAD;
                state_d    = RD_WAIT;
            end
            RD_WAIT: begin
                mem_addr_d = src_ptr_q;
                mem_cmd_d  = MREAD;
                state_d    = WR;
            end
            WR: begin
                // The bus is in its second read cycle now, so read_data holds the word to write next.
                mem_addr_d   = dst_ptr_q;
                mem_cmd_d    = MWRITE;
                write_data_d = read_data;
                src_ptr_d    = src_ptr_q + 1'b1;
                dst_ptr_d    = dst_ptr_q + 1'b1;
                words_done_d = words_done_q + 1'b1;
                remaining_d  = remaining_q - 1'b1;
                state_d      = (remaining_q == 1) ? FIN : RD_REQ;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Busy rises the cycle after start and stays up through the final bus write, dropping with done.
        busy_d = (state_d == RD_REQ) || (state_d == RD_WAIT) || (state_d == WR) || (state_q == WR);
    end

    assign mem_addr   = mem_addr_q;
    assign mem_cmd    = mem_cmd_q;
    assign write_data = write_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: bus-attached RAM/LED/switch model plus a cycle-level expectation model.
// Every cycle of each transfer is compared against timing derived from the 3-cycles-per-word rule.
module tb_mem_copy_master;

    localparam int DW = 16;
    localparam int AW = 9;
    localparam logic [15:0] SW_VALUE = 16'h005A;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr, len;
    logic [AW-1:0] mem_addr;
    logic [1:0]    mem_cmd;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data;
    logic          busy, done;
    logic [AW-1:0] words_done;

    int checks = 0;
    int passes = 0;

    logic [15:0] ram [256];
    logic [15:0] leds;
    logic        tb_clear, tb_we;
    logic [7:0]  tb_waddr;
    logic [15:0] tb_wdata;

    logic [15:0] ref_mem [256];
    logic [15:0] ref_leds;

    logic [AW-1:0] cur_src, cur_dst;
    int            cur_len, cur_rst;
    logic [15:0]   exp_data [16];
    int            done_at, done_count;

    always #5 clk = ~clk;

    mem_copy_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .mem_addr   (mem_addr),
        .mem_cmd    (mem_cmd),
        .write_data (write_data),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done),
        .words_done (words_done)
    );

    // Shared bus devices: RAM below 0x100, LEDs at 0x100, switches at 0x140, registered read.
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int i = 0; i < 256; i++) ram[i] <= 16'h0000;
            leds <= 16'h0000;
        end else if (tb_we) begin
            ram[tb_waddr] <= tb_wdata;
        end else if (mem_cmd == 2'b11) begin
            if (mem_addr < 9'h100) ram[mem_addr[7:0]] <= write_data;
            else if (mem_addr == 9'h100) leds <= write_data;
        end
        if (mem_addr < 9'h100) read_data <= ram[mem_addr[7:0]];
        else if (mem_addr == 9'h140) read_data <= SW_VALUE;
        else read_data <= 16'h0000;
    end

    function automatic logic [15:0] model_read(input logic [AW-1:0] a);
        if (a < 9'h100) return ref_mem[a[7:0]];
        if (a == 9'h140) return SW_VALUE;
        return 16'h0000;
    endfunction

    task automatic model_write(input logic [AW-1:0] a, input logic [15:0] v);
        if (a < 9'h100) ref_mem[a[7:0]] = v;
        else if (a == 9'h100) ref_leds = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    task automatic poke(input logic [7:0] a, input logic [15:0] v);
        tb_we = 1'b1;
        tb_waddr = a;
        tb_wdata = v;
        @(posedge clk); #1;
        tb_we = 1'b0;
        ref_mem[a] = v;
    endtask

    // Expected bus state k cycles after the start cycle: word i reads at 3i+2, 3i+3 and writes at 3i+4.
    task automatic checkCycle(input int k);
        logic [1:0]    e_cmd;
        logic [AW-1:0] e_addr;
        logic [15:0]   e_wd;
        logic          e_busy, e_done;
        int            e_words, i, p;
        if (cur_rst > 0 && k > cur_rst) begin
            checkOutput("rst_cmd", 32'(mem_cmd), 32'd0);
            checkOutput("rst_addr", 32'(mem_addr), 32'd0);
            checkOutput("rst_wdata", 32'(write_data), 32'd0);
            checkOutput("rst_busy", 32'(busy), 32'd0);
            checkOutput("rst_done", 32'(done), 32'd0);
            checkOutput("rst_words", 32'(words_done), 32'd0);
            return;
        end
        e_cmd  = 2'b00;
        e_addr = '0;
        e_wd   = '0;
        e_busy = (cur_len != 0) && (k <= 3 * cur_len + 1);
        e_done = (k == 3 * cur_len + 2);
        e_words = (k - 1) / 3;
        if (e_words > cur_len) e_words = cur_len;
        if (cur_len != 0 && k >= 2 && k <= 3 * cur_len + 1) begin
            i = (k - 2) / 3;
            p = (k - 2) % 3;
            if (p < 2) begin
                e_cmd  = 2'b01;
                e_addr = cur_src + AW'(i);
            end else begin
                e_cmd  = 2'b11;
                e_addr = cur_dst + AW'(i);
                e_wd   = exp_data[i];
            end
        end
        checkOutput($sformatf("cmd@%0d", k), 32'(mem_cmd), 32'(e_cmd));
        checkOutput($sformatf("busy@%0d", k), 32'(busy), 32'(e_busy));
        checkOutput($sformatf("done@%0d", k), 32'(done), 32'(e_done));
        checkOutput($sformatf("words@%0d", k), 32'(words_done), 32'(e_words));
        if (e_cmd != 2'b00) checkOutput($sformatf("addr@%0d", k), 32'(mem_addr), 32'(e_addr));
        if (e_cmd == 2'b11) checkOutput($sformatf("wdata@%0d", k), 32'(write_data), 32'(e_wd));
    endtask

    task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] d, input int l,
                                 input int rst_k, input int restart_k);
        int n_written, last;
        logic [AW-1:0] a;
        cur_src = s;
        cur_dst = d;
        cur_len = l;
        cur_rst = rst_k;
        n_written = l;
        if (rst_k > 0) begin
            n_written = 0;
            for (int i = 0; i < l; i++) if (3 * i + 4 <= rst_k) n_written++;
        end
        // Ascending word-by-word copy, so overlapping ranges see earlier writes.
        for (int i = 0; i < l; i++) begin
            a = s + AW'(i);
            exp_data[i] = model_read(a);
            if (i < n_written) model_write(d + AW'(i), exp_data[i]);
        end
        done_at = -1;
        done_count = 0;
        @(posedge clk); #1;
        src_addr = s;
        dst_addr = d;
        len = AW'(l);
        start = 1'b1;
        last = (rst_k > 0) ? rst_k + 1 : 3 * l + 4;
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            start = (k == restart_k);
            if (restart_k > 0) begin
                src_addr = 9'h050;
                dst_addr = 9'h080;
                len = 9'd3;
            end
            reset = (k == rst_k);
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                if (done_at < 0) done_at = k;
            end
            checkCycle(k);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int diffs;
        reset = 1'b1;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        tb_we = 1'b0;
        tb_waddr = '0;
        tb_wdata = '0;
        tb_clear = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'h0000;
        ref_leds = 16'h0000;
        @(posedge clk); #1;
        tb_clear = 1'b0;
        poke(8'h00, 16'h1234);
        poke(8'h10, 16'h00A1);
        poke(8'h11, 16'h00B2);
        poke(8'h12, 16'h00C3);
        poke(8'h13, 16'h00D4);
        poke(8'h40, 16'hBEEF);
        poke(8'h50, 16'h1111);
        poke(8'h51, 16'h2222);
        poke(8'h52, 16'h3333);
        poke(8'h53, 16'h4444);
        for (int i = 0; i < 4; i++) poke(8'h60 + 8'(i), 16'hFFFF);
        poke(8'h80, 16'hFFFF);

        @(negedge clk);
        checkOutput("reset_cmd", 32'(mem_cmd), 32'd0);
        checkOutput("reset_addr", 32'(mem_addr), 32'd0);
        checkOutput("reset_wdata", 32'(write_data), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_words", 32'(words_done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        $display("[TB] basic four-word copy");
        applyStimulus(9'h010, 9'h020, 4, 0, 0);
        checkOutput("t1_done_latency", 32'(done_at), 32'd14);
        checkOutput("t1_ram20", 32'(ram[8'h20]), 32'h00A1);
        checkOutput("t1_ram21", 32'(ram[8'h21]), 32'h00B2);
        checkOutput("t1_ram22", 32'(ram[8'h22]), 32'h00C3);
        checkOutput("t1_ram23", 32'(ram[8'h23]), 32'h00D4);
        checkOutput("t1_words", 32'(words_done), 32'd4);

        $display("[TB] zero-length request");
        applyStimulus(9'h030, 9'h040, 0, 0, 0);
        checkOutput("t2_done_latency", 32'(done_at), 32'd2);
        checkOutput("t2_words", 32'(words_done), 32'd0);
        checkOutput("t2_ram40", 32'(ram[8'h40]), 32'hBEEF);

        $display("[TB] source pointer wrap");
        applyStimulus(9'h1FE, 9'h0F0, 3, 0, 0);
        checkOutput("t3_ramF0", 32'(ram[8'hF0]), 32'h0000);
        checkOutput("t3_ramF1", 32'(ram[8'hF1]), 32'h0000);
        checkOutput("t3_ramF2", 32'(ram[8'hF2]), 32'h1234);

        $display("[TB] switches to LEDs");
        applyStimulus(9'h140, 9'h100, 1, 0, 0);
        checkOutput("t4_leds", 32'(leds[7:0]), 32'h5A);
        checkOutput("t4_ram00", 32'(ram[8'h00]), 32'h1234);

        $display("[TB] reset during second word");
        applyStimulus(9'h050, 9'h060, 4, 6, 0);
        checkOutput("t5_ram60", 32'(ram[8'h60]), 32'h1111);
        checkOutput("t5_ram61", 32'(ram[8'h61]), 32'hFFFF);

        $display("[TB] start pulsed while busy");
        applyStimulus(9'h010, 9'h070, 2, 0, 5);
        checkOutput("t6_ram70", 32'(ram[8'h70]), 32'h00A1);
        checkOutput("t6_ram71", 32'(ram[8'h71]), 32'h00B2);
        checkOutput("t6_ram80", 32'(ram[8'h80]), 32'hFFFF);
        checkOutput("t6_done_count", 32'(done_count), 32'd1);

        diffs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) diffs++;
        checkOutput("ram_vs_model", 32'(diffs), 32'd0);
        checkOutput("leds_vs_model", 32'(leds), 32'(ref_leds));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
